downstream_accum_ctrl: RTL and testbench
========================================

Name: downstream_accum_ctrl

Overview:
- Read-modify-write controller for the per-client cancelled-order accumulator RAM (ramdownstream, 32 x 32-bit, one registered read port, one write port).
- Accepts cancel events (client ID, amount) and adds each amount into that client's entry with a saturating add.
- Also serves host total-queries and a clear-all sweep, and flags clients whose total crosses a limit.
- Sits between the order-cancel parser and the RAM; it is the sole driver of both RAM ports.

Parameters:
- D_WIDTH, 32, accumulator and amount width.
- A_WIDTH, 5, client ID / RAM address width.
- A_MAX, 32, number of clients (2^A_WIDTH).

Ports:
- clk  input  1  single clock; RAM clk_write and clk_read are both tied to it.
- rst  input  1  synchronous, active-high reset.
- cancel_valid  input  1  cancel event offered.
- cancel_ready  output  1  cancel event accepted when valid&&ready.
- cancel_client  input  A_WIDTH  client ID of the event.
- cancel_amount  input  D_WIDTH  cancelled value to accumulate.
- query_valid  input  1  host total-query offered.
- query_ready  output  1  query accepted when valid&&ready.
- query_client  input  A_WIDTH  client to read.
- resp_valid  output  1  one-cycle pulse; resp_data is valid.
- resp_data  output  D_WIDTH  queried total.
- clear_req  input  1  pulse; request zeroing of all entries.
- limit  input  D_WIDTH  breach threshold; sampled in the UPD cycle.
- breach_valid  output  1  one-cycle pulse on a threshold crossing.
- breach_client  output  A_WIDTH  client that crossed.
- sat_err  output  1  sticky; an addition saturated.
- wr_err  output  1  sticky; memwr was not seen after a write.
- busy  output  1  high whenever state != IDLE or a clear is pending.
- downstream_address_write  output  A_WIDTH  RAM write address.
- data_write  output  D_WIDTH  RAM write data.
- downstream_write_enable  output  1  RAM write strobe.
- address_read  output  A_WIDTH  RAM read address.
- data_read  input  D_WIDTH  RAM read data, one cycle after address_read.
- memwr  input  1  RAM write acknowledge (registered).

Behaviour:
- Reset:
  - state=IDLE; all outputs 0, including write enable, readies, resp/breach pulses, sat_err, wr_err and busy.
  - clear_pending=0; rr_last=query.
  - Reset mid-operation abandons the in-flight operation. A write already committed stays in RAM; nothing else is written.
- States: IDLE, RD, UPD, QRD, QRESP, CLR.
- Fixed RAM read latency is 1: the address is driven in cycle T, and data_read is valid in T+1.
- IDLE:
  - If clear_pending, go to CLR with counter=0. Both readies are held low.
  - Otherwise arbitrate round-robin. With one requester valid, that requester gets ready. With both valid, the one not equal to rr_last gets ready.
  - Readies are combinational from state, clear_pending, the valids and rr_last.
  - Cancel accept: latch client and amount, drive address_read=client, go to RD.
  - Query accept: latch client, drive address_read, go to QRD.
- RD: hold address_read; go to UPD.
- UPD:
  - sum = data_read + amount, computed in D_WIDTH+1 bits. If bit D_WIDTH is set, write all-ones and set sat_err.
  - Assert downstream_write_enable for exactly this cycle, with address=client.
  - If old < limit and new >= limit, pulse breach_valid with breach_client the next cycle.
  - Return to IDLE; rr_last=cancel.
- QRD: go to QRESP.
- QRESP: resp_data=data_read, resp_valid=1 for one cycle; return to IDLE; rr_last=query.
- Throughput: an update takes 3 cycles (IDLE accept, RD, UPD) and a query takes 3. Back-to-back updates to the same client need no forwarding, because each write commits before the next read is sampled.
- CLR: write 0 to address counter on each cycle; counter increments. After counter=A_MAX-1, clear clear_pending and return to IDLE. A sweep takes A_MAX cycles.
- clear_req:
  - Sets clear_pending in any state. An in-flight update or query completes first.
  - clear_req during CLR is absorbed; no second sweep.
- Write-ack check: if memwr is not 1 in the cycle after any downstream_write_enable, set wr_err.
- Sticky flags clear only on rst.

Decomposition:
- Package downstream_pkg:
  - state enum ctrl_state_e.
  - D_WIDTH/A_WIDTH defaults.
  - req_sel_e {SEL_CANCEL, SEL_QUERY}.
- Sub-module rr_arb2: 2-way round-robin arbiter, combinational grant plus rr_last register. Everything else stays in the top level.

Test Plan:
- Cancel (client 3, amount 100), then (3, 50); query 3 -> resp_data=150 exactly 3 cycles after query accept. RAM[3]=150.
- Cancel (7, 0xFFFFFFF0) then (7, 0x20) -> RAM[7]=0xFFFFFFFF, sat_err=1 and stays 1.
- limit=1000; cancel (5, 600) gives no breach; (5, 500) -> breach_valid one cycle with breach_client=5. Another (5, 10) -> no breach.
- cancel_valid and query_valid held high together for 12 cycles -> grants alternate cancel/query; neither requester starves.
- Load clients 0..31 with nonzero values, pulse clear_req during an RD cycle -> the update completes, then 32 zero writes follow. Querying all clients returns 0; busy is high throughout.
- Assert rst during UPD of a cancel -> all outputs 0 the next cycle. A subsequent query returns the value as written or not written (write enable was high in the reset cycle). FSM resumes from IDLE.

Source files
------------

// File: rtl/downstream_pkg.sv
// Purpose: shared types and defaults for the cancelled-order accumulator controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package downstream_pkg;

    localparam int DEF_D_WIDTH = 32;
    localparam int DEF_A_WIDTH = 5;

    // Controller states; the top level mirrors these as plain logic constants.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_UPD   = 3'd2,
        ST_QRD   = 3'd3,
        ST_QRESP = 3'd4,
        ST_CLR   = 3'd5
    } ctrl_state_e;

    // Identifies which requester was served most recently.
    typedef enum logic {
        SEL_CANCEL = 1'b0,
        SEL_QUERY  = 1'b1
    } req_sel_e;

endpackage

// File: rtl/rr_arb2.sv
// Purpose: two-way round-robin arbiter between cancel events and host queries.
// Latency: combinational grant; rr_last updates one cycle after upd.
// Backpressure: grants only while en is high; loser sees its grant held low.
//
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   en                      - arbitration allowed this cycle
//   req_cancel, req_query   - request lines
//   upd, upd_sel            - record which requester was just served
//   grant_cancel, grant_query - one-hot (or zero) grant
module rr_arb2
    import downstream_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  logic     req_cancel,
    input  logic     req_query,
    input  logic     upd,
    input  req_sel_e upd_sel,
    output logic     grant_cancel,
    output logic     grant_query
);

    req_sel_e rr_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= SEL_QUERY;
        end else if (upd) begin
            rr_last <= upd_sel;
        end
    end

    // With both requesting, the side that was not served last wins.
    assign grant_cancel = en && req_cancel && (!req_query || (rr_last == SEL_QUERY));
    assign grant_query  = en && req_query  && (!req_cancel || (rr_last == SEL_CANCEL));

endmodule

// File: rtl/downstream_accum_ctrl.sv
// Purpose: read-modify-write controller for the per-client cancelled-order accumulator RAM.
// Latency: update 3 cycles (accept, RD, UPD); query response 3 cycles after accept; clear 32 cycles.
// Backpressure: cancel_ready/query_ready low while busy with an operation or a clear is pending.
//
// Ports:
//   clk, rst                          - clock (RAM read/write clocks tied to it), sync active-high reset
//   cancel_valid/ready/client/amount  - cancel events to accumulate
//   query_valid/ready/client          - host total-query; answered on resp_valid/resp_data
//   clear_req                         - request zeroing of every entry
//   limit, breach_valid/breach_client - threshold crossing report
//   sat_err, wr_err, busy             - sticky saturation / missing write-ack, activity
//   downstream_address_write, data_write, downstream_write_enable - RAM write port
//   address_read, data_read           - RAM read port (1-cycle registered read)
//   memwr                             - RAM write acknowledge
module downstream_accum_ctrl
    import downstream_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int A_MAX   = 1 << A_WIDTH
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cancel_valid,
    output logic               cancel_ready,
    input  logic [A_WIDTH-1:0] cancel_client,
    input  logic [D_WIDTH-1:0] cancel_amount,
    input  logic               query_valid,
    output logic               query_ready,
    input  logic [A_WIDTH-1:0] query_client,
    output logic               resp_valid,
    output logic [D_WIDTH-1:0] resp_data,
    input  logic               clear_req,
    input  logic [D_WIDTH-1:0] limit,
    output logic               breach_valid,
    output logic [A_WIDTH-1:0] breach_client,
    output logic               sat_err,
    output logic               wr_err,
    output logic               busy,
    output logic [A_WIDTH-1:0] downstream_address_write,
    output logic [D_WIDTH-1:0] data_write,
    output logic               downstream_write_enable,
    output logic [A_WIDTH-1:0] address_read,
    input  logic [D_WIDTH-1:0] data_read,
    input  logic               memwr
);

    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] RD    = ST_RD;
    localparam logic [2:0] UPD   = ST_UPD;
    localparam logic [2:0] QRD   = ST_QRD;
    localparam logic [2:0] QRESP = ST_QRESP;
    localparam logic [2:0] CLR   = ST_CLR;

    logic [2:0]         state;
    logic [A_WIDTH-1:0] lat_client;
    logic [D_WIDTH-1:0] lat_amount;
    logic [A_WIDTH-1:0] clr_cnt;
    logic               clear_pending;
    logic               we_d;

    logic               arb_en;
    logic               grant_cancel;
    logic               grant_query;
    logic               rr_upd;
    req_sel_e           rr_upd_sel;

    logic [D_WIDTH:0]   sum_ext;
    logic [D_WIDTH-1:0] sum_sat;
    logic               breach_hit;

    // Arbitration only in IDLE with no clear waiting; held off during reset so
    // nothing is ever signalled as accepted while rst is asserted.
    assign arb_en     = !rst && (state == IDLE) && !clear_pending;
    assign rr_upd     = (state == UPD) || (state == QRESP);
    assign rr_upd_sel = (state == UPD) ? SEL_CANCEL : SEL_QUERY;

    rr_arb2 u_arb (
        .clk          (clk),
        .rst          (rst),
        .en           (arb_en),
        .req_cancel   (cancel_valid),
        .req_query    (query_valid),
        .upd          (rr_upd),
        .upd_sel      (rr_upd_sel),
        .grant_cancel (grant_cancel),
        .grant_query  (grant_query)
    );

    assign cancel_ready = grant_cancel;
    assign query_ready  = grant_query;
    assign busy         = (state != IDLE) || clear_pending;

    // Carry out of the wide add means the true total no longer fits: clamp.
    assign sum_ext    = {1'b0, data_read} + {1'b0, lat_amount};
    assign sum_sat    = sum_ext[D_WIDTH] ? {D_WIDTH{1'b1}} : sum_ext[D_WIDTH-1:0];
    assign breach_hit = (data_read < limit) && (sum_sat >= limit);

    // RAM port drive. The read address is presented in the accept cycle and
    // held through the following state so data_read stays valid where used.
    always_comb begin
        address_read             = '0;
        downstream_address_write = '0;
        data_write               = '0;
        downstream_write_enable  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_cancel) begin
                    address_read = cancel_client;
                end else if (grant_query) begin
                    address_read = query_client;
                end
            end
            RD, QRD, QRESP: begin
                address_read = lat_client;
            end
            UPD: begin
                address_read             = lat_client;
                downstream_address_write = lat_client;
                data_write               = sum_sat;
                downstream_write_enable  = 1'b1;
            end
            CLR: begin
                downstream_address_write = clr_cnt;
                downstream_write_enable  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            lat_client    <= '0;
            lat_amount    <= '0;
            clr_cnt       <= '0;
            clear_pending <= 1'b0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            breach_valid  <= 1'b0;
            breach_client <= '0;
            sat_err       <= 1'b0;
            wr_err        <= 1'b0;
            we_d          <= 1'b0;
        end else begin
            resp_valid   <= 1'b0;
            breach_valid <= 1'b0;
            we_d         <= downstream_write_enable;

            // The RAM acknowledges one cycle after every write strobe.
            if (we_d && !memwr) begin
                wr_err <= 1'b1;
            end

            // A request arriving mid-sweep is folded into the running sweep.
            if (clear_req && (state != CLR)) begin
                clear_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (clear_pending) begin
                        clr_cnt <= '0;
                        state   <= CLR;
                    end else if (grant_cancel) begin
                        lat_client <= cancel_client;
                        lat_amount <= cancel_amount;
                        state      <= RD;
                    end else if (grant_query) begin
                        lat_client <= query_client;
                        state      <= QRD;
                    end
                end
                RD: begin
                    state <= UPD;
                end
                UPD: begin
                    if (sum_ext[D_WIDTH]) begin
                        sat_err <= 1'b1;
                    end
                    if (breach_hit) begin
                        breach_valid  <= 1'b1;
                        breach_client <= lat_client;
                    end
                    state <= IDLE;
                end
                QRD: begin
                    state <= QRESP;
                end
                QRESP: begin
                    resp_valid <= 1'b1;
                    resp_data  <= data_read;
                    state      <= IDLE;
                end
                CLR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == A_WIDTH'(A_MAX - 1)) begin
                        clear_pending <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_downstream_accum_ctrl.sv
// Purpose: directed self-checking bench for downstream_accum_ctrl with a behavioural RAM.
// Latency: RAM model reads one cycle after the address, acks writes one cycle later.
// Backpressure: stimulus holds valid until ready is seen, bounded by a cycle budget.
module tb_downstream_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cancel_valid = 1'b0;
    logic        cancel_ready;
    logic [4:0]  cancel_client = '0;
    logic [31:0] cancel_amount = '0;
    logic        query_valid = 1'b0;
    logic        query_ready;
    logic [4:0]  query_client = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        clear_req = 1'b0;
    logic [31:0] limit = '0;
    logic        breach_valid;
    logic [4:0]  breach_client;
    logic        sat_err;
    logic        wr_err;
    logic        busy;
    logic [4:0]  downstream_address_write;
    logic [31:0] data_write;
    logic        downstream_write_enable;
    logic [4:0]  address_read;
    logic [31:0] data_read = '0;
    logic        memwr = 1'b0;

    logic [31:0] mem [32] = '{default: '0};
    logic        memwr_kill = 1'b0;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int breach_cnt = 0;
    logic [4:0] last_breach = '0;

    always #5 clk = ~clk;

    downstream_accum_ctrl dut (
        .clk                      (clk),
        .rst                      (rst),
        .cancel_valid             (cancel_valid),
        .cancel_ready             (cancel_ready),
        .cancel_client            (cancel_client),
        .cancel_amount            (cancel_amount),
        .query_valid              (query_valid),
        .query_ready              (query_ready),
        .query_client             (query_client),
        .resp_valid               (resp_valid),
        .resp_data                (resp_data),
        .clear_req                (clear_req),
        .limit                    (limit),
        .breach_valid             (breach_valid),
        .breach_client            (breach_client),
        .sat_err                  (sat_err),
        .wr_err                   (wr_err),
        .busy                     (busy),
        .downstream_address_write (downstream_address_write),
        .data_write               (data_write),
        .downstream_write_enable  (downstream_write_enable),
        .address_read             (address_read),
        .data_read                (data_read),
        .memwr                    (memwr)
    );

    // Behavioural RAM: read-first registered read, registered write ack.
    always @(posedge clk) begin
        data_read <= mem[address_read];
        memwr     <= downstream_write_enable && !memwr_kill;
        if (downstream_write_enable) begin
            mem[downstream_address_write] <= data_write;
        end
    end

    always @(negedge clk) begin
        if (breach_valid) begin
            breach_cnt  <= breach_cnt + 1;
            last_breach <= breach_client;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 200), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Returns at the negedge of the RD cycle with cancel_valid dropped.
    task automatic send_cancel(input logic [4:0] c, input logic [31:0] a);
        int n = 0;
        cancel_valid  = 1'b1;
        cancel_client = c;
        cancel_amount = a;
        #1;
        while (!cancel_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("cancel_accept", 32'(cancel_ready), 32'd1);
        @(negedge clk);
        cancel_valid = 1'b0;
    endtask

    task automatic send_query(input logic [4:0] c, output logic [31:0] d, output int lat);
        int n = 0;
        query_valid  = 1'b1;
        query_client = c;
        #1;
        while (!query_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("query_accept", 32'(query_ready), 32'd1);
        lat = 0;
        d   = 'x;
        @(negedge clk);
        query_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (resp_valid && lat == 0) begin
                lat = k;
                d   = resp_data;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] d;
        int          lat;
        int          bc;
        int          g;
        logic [3:0]  gseq;
        int          zero_w;
        int          upd_w;
        int          extra_w;
        logic        order_ok;
        logic        busy_ok;
        logic        sent;
        int          nz;
        int          latbad;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctrl", {24'd0, cancel_ready, query_ready, resp_valid, breach_valid,
                         sat_err, wr_err, busy, downstream_write_enable}, 32'd0);
        chk("rst_addr", {22'd0, address_read, downstream_address_write}, 32'd0);
        chk("rst_wdata", data_write, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Accumulate and query
        send_cancel(5'd3, 32'd100); wait_idle();
        send_cancel(5'd3, 32'd50);  wait_idle();
        send_query(5'd3, d, lat);
        chk("q3_data", d, 32'd150);
        chk("q3_latency", 32'(lat), 32'd3);
        chk("ram3", mem[3], 32'd150);
        send_query(5'd4, d, lat);
        chk("q4_data", d, 32'd0);

        // Saturation
        send_cancel(5'd7, 32'hFFFF_FFF0); wait_idle();
        chk("sat_before", 32'(sat_err), 32'd0);
        send_cancel(5'd7, 32'h20); wait_idle();
        chk("ram7_sat", mem[7], 32'hFFFF_FFFF);
        chk("sat_set", 32'(sat_err), 32'd1);
        send_cancel(5'd1, 32'd1); wait_idle();
        chk("sat_sticky", 32'(sat_err), 32'd1);

        // Breach detection
        limit = 32'd1000;
        bc = breach_cnt;
        send_cancel(5'd5, 32'd600); wait_idle();
        chk("breach_600", 32'(breach_cnt - bc), 32'd0);
        send_cancel(5'd5, 32'd500); wait_idle();
        chk("breach_1100", 32'(breach_cnt - bc), 32'd1);
        chk("breach_client", 32'(last_breach), 32'd5);
        send_cancel(5'd5, 32'd10); wait_idle();
        chk("breach_again", 32'(breach_cnt - bc), 32'd1);
        limit = 32'd0;

        // Round-robin fairness: last op was a cancel, so query wins first.
        cancel_client = 5'd10;
        cancel_amount = 32'd1;
        query_client  = 5'd10;
        cancel_valid  = 1'b1;
        query_valid   = 1'b1;
        g    = 0;
        gseq = '0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (cancel_ready) begin
                if (g < 4) gseq[g] = 1'b0;
                g++;
            end else if (query_ready) begin
                if (g < 4) gseq[g] = 1'b1;
                g++;
            end
            @(negedge clk);
        end
        cancel_valid = 1'b0;
        query_valid  = 1'b0;
        wait_idle();
        chk("rr_grants", 32'(g), 32'd4);
        chk("rr_order", 32'(gseq), 32'b0101);
        chk("ram10", mem[10], 32'd2);

        // Clear sweep requested during an update's RD cycle
        for (int i = 0; i < 32; i++) begin
            send_cancel(5'(i), 32'(i + 1));
            wait_idle();
        end
        send_cancel(5'd0, 32'd5);
        clear_req = 1'b1;
        zero_w   = 0;
        upd_w    = 0;
        order_ok = 1'b1;
        busy_ok  = 1'b1;
        sent     = 1'b0;
        for (int n = 0; n < 80 && zero_w < 32; n++) begin
            #1;
            if (!busy) busy_ok = 1'b0;
            if (downstream_write_enable) begin
                if (data_write == 32'd0) begin
                    if (downstream_address_write != 5'(zero_w)) order_ok = 1'b0;
                    zero_w++;
                end else begin
                    upd_w++;
                end
            end
            @(negedge clk);
            clear_req = 1'b0;
            if (zero_w == 10 && !sent) begin
                clear_req = 1'b1;
                sent      = 1'b1;
            end
        end
        clear_req = 1'b0;
        chk("clr_upd_writes", 32'(upd_w), 32'd1);
        chk("clr_zero_writes", 32'(zero_w), 32'd32);
        chk("clr_order", 32'(order_ok), 32'd1);
        chk("clr_busy", 32'(busy_ok), 32'd1);
        #1;
        chk("clr_done_busy", 32'(busy), 32'd0);
        extra_w = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (downstream_write_enable) extra_w++;
        end
        chk("clr_absorbed", 32'(extra_w), 32'd0);
        nz     = 0;
        latbad = 0;
        for (int i = 0; i < 32; i++) begin
            send_query(5'(i), d, lat);
            if (d !== 32'd0) nz++;
            if (lat != 3) latbad++;
        end
        chk("clr_query_zero", 32'(nz), 32'd0);
        chk("clr_query_lat", 32'(latbad), 32'd0);

        // Missing write acknowledge
        chk("wr_err_before", 32'(wr_err), 32'd0);
        memwr_kill = 1'b1;
        send_cancel(5'd2, 32'd4); wait_idle();
        memwr_kill = 1'b0;
        chk("wr_err_set", 32'(wr_err), 32'd1);

        // Reset during UPD
        send_cancel(5'd9, 32'd77);
        @(negedge clk);
        #1;
        chk("upd_we", 32'(downstream_write_enable), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rstupd_ctrl", {24'd0, cancel_ready, query_ready, resp_valid, breach_valid,
                            sat_err, wr_err, busy, downstream_write_enable}, 32'd0);
        chk("rstupd_addr", {22'd0, address_read, downstream_address_write}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        send_query(5'd9, d, lat);
        chk("rstupd_q9", d, 32'd77);
        chk("rstupd_ram9", mem[9], 32'd77);
        send_cancel(5'd9, 32'd3); wait_idle();
        send_query(5'd9, d, lat);
        chk("resume_q9", d, 32'd80);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
